// File: rtl/reg_file_resp.sv
// Register file with two request/strobe read ports and a writeback port.
// Each read port runs its own IDLE/WAIT/RESP handshake: a read of a register
// that is marked busy (pending writeback) is held in WAIT until the matching
// writeback arrives, and the written value is forwarded straight to the port.
module reg_file_resp #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] Rd1_addr,
  input  logic [REG_ADDR_LEN-1:0] Rd2_addr,
  input  logic                    Rd1_en,
  input  logic                    Rd2_en,
  output logic [WIDTH-1:0]        Rd1_data,
  output logic [WIDTH-1:0]        Rd2_data,
  output logic                    Rd1_st,
  output logic                    Rd2_st,
  input  logic [REG_ADDR_LEN-1:0] Wr_addr,
  input  logic [WIDTH-1:0]        Wr_data,
  input  logic                    Wr_en,
  input  logic                    Busy_set,
  input  logic [REG_ADDR_LEN-1:0] Busy_addr,
  output logic                    Rd_wait
);

  localparam int NREG = 1 << REG_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [WIDTH-1:0]        regs     [NREG];
  logic [NREG-1:0]         busy;

  state_t                  state    [2];
  logic [REG_ADDR_LEN-1:0] lat_addr [2];
  logic                    served   [2];
  logic [WIDTH-1:0]        data_q   [2];
  logic                    st_q     [2];

  logic [REG_ADDR_LEN-1:0] req_addr [2];
  logic                    req_en   [2];

  assign req_addr[0] = Rd1_addr;
  assign req_addr[1] = Rd2_addr;
  assign req_en[0]   = Rd1_en;
  assign req_en[1]   = Rd2_en;

  assign Rd1_data = data_q[0];
  assign Rd2_data = data_q[1];
  assign Rd1_st   = st_q[0];
  assign Rd2_st   = st_q[1];
  assign Rd_wait  = (state[0] == WAIT) || (state[1] == WAIT);

  // Register storage and pending-write scoreboard; a same-edge Busy_set wins
  // over the writeback clear because it belongs to a newer instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (Wr_en && (Wr_addr != '0)) regs[Wr_addr] <= Wr_data;
      if (Wr_en) busy[Wr_addr] <= 1'b0;
      if (Busy_set && (Busy_addr != '0)) busy[Busy_addr] <= 1'b1;
    end
  end

  // Per-port read handshake; st is registered so it is high exactly in RESP.
  // A writeback on the acceptance edge resolves a busy register immediately,
  // otherwise the write would be missed and the port would wait forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        state[p]    <= IDLE;
        lat_addr[p] <= '0;
        served[p]   <= 1'b0;
        data_q[p]   <= '0;
        st_q[p]     <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        st_q[p] <= 1'b0;
        if (!req_en[p] || (req_addr[p] != lat_addr[p])) served[p] <= 1'b0;
        case (state[p])
          IDLE: begin
            if (req_en[p] && !(served[p] && (req_addr[p] == lat_addr[p]))) begin
              lat_addr[p] <= req_addr[p];
              if (req_addr[p] == '0) begin
                state[p]  <= RESP;
                data_q[p] <= '0;
                st_q[p]   <= 1'b1;
              end else if (Wr_en && (Wr_addr == req_addr[p])) begin
                state[p]  <= RESP;
                data_q[p] <= Wr_data;
                st_q[p]   <= 1'b1;
              end else if (!busy[req_addr[p]]) begin
                state[p]  <= RESP;
                data_q[p] <= regs[req_addr[p]];
                st_q[p]   <= 1'b1;
              end else begin
                state[p]  <= WAIT;
              end
            end
          end
          WAIT: begin
            if (!req_en[p]) begin
              state[p] <= IDLE;
            end else if (Wr_en && (Wr_addr == lat_addr[p])) begin
              state[p]  <= RESP;
              data_q[p] <= Wr_data;
              st_q[p]   <= 1'b1;
            end
          end
          RESP: begin
            state[p]  <= IDLE;
            served[p] <= req_en[p] && (req_addr[p] == lat_addr[p]);
          end
          default: state[p] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/reg_file_resp.md
REG_FILE_RESP -- requirements
Module: reg_file_resp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width.
REQ-002 SHALL have parameter REG_ADDR_LEN, default 5, meaning register address width (2^REG_ADDR_LEN registers).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports Rd1_addr / Rd2_addr  input  REG_ADDR_LEN  read-port register address.
REQ-006 SHALL have ports Rd1_en / Rd2_en  input  1  read-port request level, held by the decode stage until served.
REQ-007 SHALL have ports Rd1_data / Rd2_data  output  WIDTH  registered read data.
REQ-008 SHALL have ports Rd1_st / Rd2_st  output  1  one-cycle strobe, data valid.
REQ-009 SHALL have ports Wr_addr  input  REG_ADDR_LEN, Wr_data  input  WIDTH, Wr_en  input  1  writeback port.
REQ-010 SHALL have ports Busy_set  input  1, Busy_addr  input  REG_ADDR_LEN  mark register as pending-write at issue.
REQ-011 SHALL have port Rd_wait  output  1  high while either read port is in WAIT.

Function
REQ-012 SHALL hold 2^REG_ADDR_LEN registers of WIDTH bits; register 0 always reads 0; writes to register 0 ignored.
REQ-013 SHALL write Wr_data to Wr_addr on the clock edge where Wr_en=1 and clear busy[Wr_addr] on that edge.
REQ-014 SHALL set busy[Busy_addr] on the edge where Busy_set=1 (Busy_addr≠0); on same-address Busy_set and Wr_en, write happens and busy ends set.
REQ-015 SHALL run one independent FSM per read port, states IDLE, WAIT, RESP.
REQ-016 SHALL accept a request in IDLE when en=1 and the port is not marked served; latch the address.
REQ-017 SHALL mark a port served on the RESP cycle; clear served when en=0 or address differs from the latched address.
REQ-018 SHALL go IDLE->RESP on acceptance when busy[addr]=0 or addr=0; else IDLE->WAIT.
REQ-019 SHALL go WAIT->RESP on the edge where Wr_en=1 with Wr_addr equal to the latched address, capturing Wr_data.
REQ-020 SHALL abort WAIT to IDLE with no strobe if en drops while waiting.
REQ-021 SHALL assert st for exactly one cycle in RESP, with data stable that cycle, then return to IDLE; latency 1 cycle from acceptance when not busy.
REQ-022 SHALL bypass: a read accepted on the same edge as a Wr_en to the same nonzero address returns Wr_data.
REQ-023 SHALL hold Rd*_data at last delivered value outside RESP.
REQ-024 SHALL serve both ports in parallel, including same address on the same cycle.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear all registers, all busy bits, served flags, Rd*_data=0, Rd*_st=0, Rd_wait=0, FSMs to IDLE.
REQ-026 SHALL give reset priority over all inputs; reset mid-WAIT or mid-RESP aborts with no strobe after the reset edge.

Verification
REQ-027 Write R5=0x0000_1234; hold Rd1_en=1, Rd1_addr=5 -> Rd1_st one cycle later, Rd1_data=0x0000_1234, single pulse while en held.
REQ-028 Busy_set R7; request Rd2 addr 7 -> Rd_wait=1, no strobe; Wr R7=0xDEAD_BEEF 3 cycles later -> Rd2_st next cycle with 0xDEAD_BEEF, Rd_wait=0.
REQ-029 Wr R0=0xFFFF_FFFF, read addr 0 on both ports -> both strobe same cycle, data 0.
REQ-030 Request Rd1 addr 9 on same edge as Wr R9=0x55 -> Rd1_data=0x55.
REQ-031 Hold Rd1_en, change Rd1_addr 3->4 -> second strobe with R4 contents; drop en during WAIT -> no strobe, FSM IDLE.
REQ-032 Assert rst during WAIT -> no strobe, all outputs 0, busy cleared; subsequent read of any register returns 0.
